// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types and default widths for the GEMM job scheduler.
package gemm_pkg;

   localparam int GEMM_DIM_W = 8;
   localparam int GEMM_K_W   = 16;
   localparam int GEMM_ACC_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      EMIT  = 3'd3,
      FIN   = 3'd4
   } gemm_sched_state_e;

   typedef struct packed {
      logic [GEMM_DIM_W-1:0] row;
      logic [GEMM_DIM_W-1:0] col;
      logic                  last;
   } out_tag_t;

endpackage

// File: rtl/gemm_sched_if.sv
// gemm_sched_if: job, vec_mac and result-stream signals of the scheduler.
// With GEMM_SCHED_PERF_EN defined the performance counters are carried too.
interface gemm_sched_if
   import gemm_pkg::*;
#(
   parameter int DIM_W = GEMM_DIM_W,
   parameter int K_W   = GEMM_K_W,
   parameter int ACC_W = GEMM_ACC_W
) ();
   logic             job_valid;
   logic             job_ready;
   logic [DIM_W-1:0] job_m;
   logic [DIM_W-1:0] job_p;
   logic [K_W-1:0]   job_k;
   logic             mac_start;
   logic [K_W-1:0]   mac_row_size;
   logic [DIM_W-1:0] a_row_idx;
   logic [DIM_W-1:0] b_col_idx;
   logic             mac_done;
   logic [ACC_W-1:0] mac_result;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [DIM_W-1:0] out_row;
   logic [DIM_W-1:0] out_col;
   logic             out_last;
   logic             busy;
   logic             job_done;
`ifdef GEMM_SCHED_PERF_EN
   logic [31:0]      perf_cycles;
   logic [31:0]      perf_stalls;
`endif

   modport master (
      input  job_valid, job_m, job_p, job_k, mac_done, mac_result, out_ready,
      output job_ready, mac_start, mac_row_size, a_row_idx, b_col_idx,
             out_valid, out_data, out_row, out_col, out_last, busy, job_done
`ifdef GEMM_SCHED_PERF_EN
      , output perf_cycles, perf_stalls
`endif
   );

   modport slave (
      output job_valid, job_m, job_p, job_k, mac_done, mac_result, out_ready,
      input  job_ready, mac_start, mac_row_size, a_row_idx, b_col_idx,
             out_valid, out_data, out_row, out_col, out_last, busy, job_done
`ifdef GEMM_SCHED_PERF_EN
      , input perf_cycles, perf_stalls
`endif
   );

endinterface

// File: rtl/gemm_idx_cnt.sv
// gemm_idx_cnt: row-major (i, j) walker over an m x p output grid.
module gemm_idx_cnt #(
   parameter int DIM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   input  logic [DIM_W-1:0] m,
   input  logic [DIM_W-1:0] p,
   output logic [DIM_W-1:0] i,
   output logic [DIM_W-1:0] j,
   output logic             last
);
   logic [DIM_W-1:0] i_q, i_d, j_q, j_d;

   // Clear to (0,0) or step j, wrapping into the next row at the last column.
   always_comb begin
      i_d = i_q;
      j_d = j_q;
      if (clr) begin
         i_d = '0;
         j_d = '0;
      end else if (adv) begin
         if (j_q == p - DIM_W'(1)) begin
            j_d = '0;
            i_d = i_q + DIM_W'(1);
         end else begin
            j_d = j_q + DIM_W'(1);
         end
      end
   end

   // Index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_q <= '0;
         j_q <= '0;
      end else begin
         i_q <= i_d;
         j_q <= j_d;
      end
   end

   assign i    = i_q;
   assign j    = j_q;
   assign last = (i_q == m - DIM_W'(1)) && (j_q == p - DIM_W'(1));

endmodule

// File: rtl/gemm_sched.sv
// gemm_sched: walks a C[M][P] job element by element through one vec_mac,
// one MAC outstanding at a time, and streams tagged results out.
// Optional feature macro: GEMM_SCHED_PERF_EN (busy-cycle and stall counters).
module gemm_sched
   import gemm_pkg::*;
#(
   parameter int DIM_W = GEMM_DIM_W,
   parameter int K_W   = GEMM_K_W,
   parameter int ACC_W = GEMM_ACC_W
) (
   input logic          clk,
   input logic          rst,
   gemm_sched_if.master bus
);
   gemm_sched_state_e state_q, state_d;
   logic [DIM_W-1:0]  m_q, m_d, p_q, p_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [ACC_W-1:0]  out_data_q, out_data_d;
   logic [DIM_W-1:0]  out_row_q, out_row_d, out_col_q, out_col_d;
   logic              out_last_q, out_last_d;
   logic              idx_clr, idx_adv, idx_last;
   logic [DIM_W-1:0]  idx_i, idx_j;

   gemm_idx_cnt #(.DIM_W(DIM_W)) u_idx (
      .clk  (clk),
      .rst  (rst),
      .clr  (idx_clr),
      .adv  (idx_adv),
      .m    (m_q),
      .p    (p_q),
      .i    (idx_i),
      .j    (idx_j),
      .last (idx_last)
   );

   // Scheduler FSM: next state, job latches, result capture and index control.
   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      p_d        = p_q;
      k_d        = k_q;
      out_data_d = out_data_q;
      out_row_d  = out_row_q;
      out_col_d  = out_col_q;
      out_last_d = out_last_q;
      idx_clr    = 1'b0;
      idx_adv    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.job_valid) begin
               m_d     = bus.job_m;
               p_d     = bus.job_p;
               k_d     = bus.job_k;
               idx_clr = 1'b1;
               // An empty job still completes with a job_done pulse.
               if ((bus.job_m == '0) || (bus.job_p == '0) || (bus.job_k == '0)) begin
                  state_d = FIN;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (bus.mac_done) begin
               out_data_d = bus.mac_result;
               out_row_d  = idx_i;
               out_col_d  = idx_j;
               out_last_d = idx_last;
               state_d    = EMIT;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               if (out_last_q) begin
                  state_d = FIN;
               end else begin
                  idx_adv = 1'b1;
                  state_d = ISSUE;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, job and output registers; reset aborts any job in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         m_q        <= '0;
         p_q        <= '0;
         k_q        <= '0;
         out_data_q <= '0;
         out_row_q  <= '0;
         out_col_q  <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         p_q        <= p_d;
         k_q        <= k_d;
         out_data_q <= out_data_d;
         out_row_q  <= out_row_d;
         out_col_q  <= out_col_d;
         out_last_q <= out_last_d;
      end
   end

   // Indices only move on a result handshake, so they stay put from mac_start
   // until the corresponding output has been accepted.
   assign bus.job_ready    = (state_q == IDLE);
   assign bus.busy         = (state_q != IDLE);
   assign bus.mac_start    = (state_q == ISSUE);
   assign bus.job_done     = (state_q == FIN);
   assign bus.out_valid    = (state_q == EMIT);
   assign bus.mac_row_size = k_q;
   assign bus.a_row_idx    = idx_i;
   assign bus.b_col_idx    = idx_j;
   assign bus.out_data     = out_data_q;
   assign bus.out_row      = out_row_q;
   assign bus.out_col      = out_col_q;
   assign bus.out_last     = out_last_q;

`ifdef GEMM_SCHED_PERF_EN
   logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

   // Saturating busy/stall counters, cleared when a job is accepted.
   always_comb begin
      perf_cycles_d = perf_cycles_q;
      perf_stalls_d = perf_stalls_q;
      if ((state_q == IDLE) && bus.job_valid) begin
         perf_cycles_d = '0;
         perf_stalls_d = '0;
      end else begin
         if ((state_q != IDLE) && (perf_cycles_q != '1)) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
         end
         if ((state_q == EMIT) && !bus.out_ready && (perf_stalls_q != '1)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_d;
         perf_stalls_q <= perf_stalls_d;
      end
   end

   assign bus.perf_cycles = perf_cycles_q;
   assign bus.perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_gemm_sched.sv
// tb_gemm_sched: scoreboard bench for gemm_sched with a behavioural vec_mac
// (mac_done 5 cycles after mac_start, result = 100*row + col).
module tb_gemm_sched;
   import gemm_pkg::*;

   localparam int DIM_W = 8;
   localparam int K_W   = 16;
   localparam int ACC_W = 32;

   typedef struct {
      logic [ACC_W-1:0] data;
      out_tag_t         tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   starts = 0;
   exp_t sbq[$];

   logic             pend;
   int               cd;
   logic [ACC_W-1:0] res;

   gemm_sched_if #(.DIM_W(DIM_W), .K_W(K_W), .ACC_W(ACC_W)) bus ();

   gemm_sched #(.DIM_W(DIM_W), .K_W(K_W), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // vec_mac model
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend           <= 1'b0;
         cd             <= 0;
         res            <= '0;
         bus.mac_done   <= 1'b0;
         bus.mac_result <= '0;
      end else begin
         bus.mac_done <= 1'b0;
         if (bus.mac_start) begin
            pend   <= 1'b1;
            cd     <= 4;
            res    <= ACC_W'(100 * int'(bus.a_row_idx) + int'(bus.b_col_idx));
            starts <= starts + 1;
         end else if (pend) begin
            if (cd == 1) begin
               bus.mac_done   <= 1'b1;
               bus.mac_result <= res;
               pend           <= 1'b0;
            end
            cd <= cd - 1;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic start_job(input int m, input int p, input int k);
      exp_t e;
      bus.job_m     = DIM_W'(m);
      bus.job_p     = DIM_W'(p);
      bus.job_k     = K_W'(k);
      bus.job_valid = 1'b1;
      for (int c = 0; c < 300 && !bus.job_ready; c++) @(negedge clk);
      if (!bus.job_ready) begin
         total++; bad++;
         $display("FAIL job_accept got=job_ready 0 exp=1 within budget");
      end
      @(negedge clk);
      bus.job_valid = 1'b0;
      for (int i = 0; i < m; i++) begin
         for (int j = 0; j < p; j++) begin
            e.data     = ACC_W'(100 * i + j);
            e.tag.row  = DIM_W'(i);
            e.tag.col  = DIM_W'(j);
            e.tag.last = (i == m - 1) && (j == p - 1);
            sbq.push_back(e);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (bus.job_ready !== 1'b1) begin bad++; $display("FAIL rst_job_ready got=%b exp=1", bus.job_ready); end
      total++;
      if ({bus.busy, bus.mac_start, bus.out_valid, bus.job_done, bus.out_last} !== 5'b0) begin
         bad++; $display("FAIL rst_ctrl got=%b exp=00000", {bus.busy, bus.mac_start, bus.out_valid, bus.job_done, bus.out_last});
      end
      total++;
      if ({bus.out_data, bus.out_row, bus.out_col, bus.a_row_idx, bus.b_col_idx, bus.mac_row_size} !== '0) begin
         bad++; $display("FAIL rst_data got=%h/%h/%h/%h/%h/%h exp=0", bus.out_data, bus.out_row, bus.out_col,
                         bus.a_row_idx, bus.b_col_idx, bus.mac_row_size);
      end
`ifdef GEMM_SCHED_PERF_EN
      total++;
      if ({bus.perf_cycles, bus.perf_stalls} !== 64'd0) begin
         bad++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", bus.perf_cycles, bus.perf_stalls);
      end
`endif
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int   hs_cyc = -1;
      int   done_cyc = -1;
      int   ndone = 0;
      int   s0;
      exp_t e;
      bus.out_ready = 1'b1;
      s0 = starts;
      start_job(2, 3, 32);
      for (int c = 0; c < 300; c++) begin
         if (bus.mac_start) begin
            total++;
            if (bus.mac_row_size !== 16'd32) begin bad++; $display("FAIL t1_row_size got=%0d exp=32", bus.mac_row_size); end
         end
         if (bus.out_valid && bus.out_ready) begin
            total++;
            if (sbq.size() == 0) begin
               bad++; $display("FAIL t1_out got=extra %h exp=none", bus.out_data);
            end else begin
               e = sbq.pop_front();
               if ({bus.out_data, bus.out_row, bus.out_col, bus.out_last} !== {e.data, e.tag.row, e.tag.col, e.tag.last}) begin
                  bad++; $display("FAIL t1_out got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", bus.out_data, bus.out_row,
                                  bus.out_col, bus.out_last, e.data, e.tag.row, e.tag.col, e.tag.last);
               end
            end
            hs_cyc = c;
         end
         if (bus.job_done) begin done_cyc = c; ndone++; end
         if (done_cyc >= 0 && c > done_cyc + 2) break;
         @(negedge clk);
      end
      total++;
      if (starts - s0 != 6) begin bad++; $display("FAIL t1_starts got=%0d exp=6", starts - s0); end
      total++;
      if (ndone != 1) begin bad++; $display("FAIL t1_job_done_count got=%0d exp=1", ndone); end
      total++;
      if (done_cyc != hs_cyc + 1) begin bad++; $display("FAIL t1_done_latency got=%0d exp=%0d", done_cyc, hs_cyc + 1); end
      total++;
      if (sbq.size() != 0) begin bad++; $display("FAIL t1_missing got=%0d left exp=0", sbq.size()); sbq.delete(); end
   endtask

   task automatic test_stall();
      exp_t e;
      bit   seen_done = 1'b0;
      bus.out_ready = 1'b0;
      start_job(1, 2, 4);
      for (int c = 0; c < 100 && !bus.out_valid; c++) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         total++;
         if ({bus.out_valid, bus.mac_start, bus.out_data} !== {1'b1, 1'b0, 32'd0}) begin
            bad++; $display("FAIL t2_stall%0d got=v%b s%b d%0d exp=v1 s0 d0", s, bus.out_valid, bus.mac_start, bus.out_data);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      e = sbq.pop_front();
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_last} !== {1'b1, e.data, e.tag.row, e.tag.col, e.tag.last}) begin
         bad++; $display("FAIL t2_out0 got=v%b %0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", bus.out_valid, bus.out_data, bus.out_row,
                         bus.out_col, bus.out_last, e.data, e.tag.row, e.tag.col, e.tag.last);
      end
      @(negedge clk);
      total++;
      if (bus.mac_start !== 1'b1) begin bad++; $display("FAIL t2_restart got=%b exp=1", bus.mac_start); end
      for (int c = 0; c < 100 && !seen_done; c++) begin
         if (bus.out_valid) begin
            e = sbq.pop_front();
            total++;
            if ({bus.out_data, bus.out_row, bus.out_col, bus.out_last} !== {e.data, e.tag.row, e.tag.col, e.tag.last}) begin
               bad++; $display("FAIL t2_out1 got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", bus.out_data, bus.out_row,
                               bus.out_col, bus.out_last, e.data, e.tag.row, e.tag.col, e.tag.last);
            end
         end
         seen_done = bus.job_done;
         @(negedge clk);
      end
      total++;
      if (!seen_done || sbq.size() != 0) begin bad++; $display("FAIL t2_end got=done%b left%0d exp=done1 left0", seen_done, sbq.size()); sbq.delete(); end
   endtask

   task automatic test_zero_dim();
      int s0;
      s0 = starts;
      start_job(0, 4, 8);
      total++;
      if ({bus.job_done, bus.mac_start, bus.busy} !== 3'b101) begin
         bad++; $display("FAIL t3_fin got=done%b start%b busy%b exp=101", bus.job_done, bus.mac_start, bus.busy);
      end
      @(negedge clk);
      total++;
      if ({bus.job_ready, bus.job_done, bus.busy} !== 3'b100) begin
         bad++; $display("FAIL t3_idle got=ready%b done%b busy%b exp=100", bus.job_ready, bus.job_done, bus.busy);
      end
      repeat (3) @(negedge clk);
      total++;
      if (starts != s0) begin bad++; $display("FAIL t3_no_start got=%0d exp=0", starts - s0); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit   seen_done = 1'b0;
      int   ready_bad = 0;
      bus.out_ready = 1'b1;
      start_job(2, 3, 32);
      bus.job_m = 8'd1; bus.job_p = 8'd1; bus.job_k = 16'd7; bus.job_valid = 1'b1;
      for (int c = 0; c < 300 && !seen_done; c++) begin
         if (bus.busy && bus.job_ready !== 1'b0) ready_bad++;
         if (bus.out_valid) begin
            e = sbq.pop_front();
            total++;
            if ({bus.out_data, bus.out_row, bus.out_col, bus.out_last} !== {e.data, e.tag.row, e.tag.col, e.tag.last}) begin
               bad++; $display("FAIL t4_out got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", bus.out_data, bus.out_row,
                               bus.out_col, bus.out_last, e.data, e.tag.row, e.tag.col, e.tag.last);
            end
         end
         seen_done = bus.job_done;
         if (!seen_done) @(negedge clk);
      end
      total++;
      if (ready_bad != 0 || !seen_done) begin bad++; $display("FAIL t4_busy_ready got=%0d ready-high cycles done%b exp=0 done1", ready_bad, seen_done); end
      @(negedge clk);
      total++;
      if ({bus.job_ready, bus.busy} !== 2'b10) begin bad++; $display("FAIL t4_idle got=ready%b busy%b exp=10", bus.job_ready, bus.busy); end
      @(negedge clk);
      bus.job_valid = 1'b0;
      e.data = '0; e.tag.row = '0; e.tag.col = '0; e.tag.last = 1'b1;
      sbq.push_back(e);
      total++;
      if ({bus.mac_start, bus.mac_row_size} !== {1'b1, 16'd7}) begin
         bad++; $display("FAIL t4_second got=start%b k%0d exp=start1 k7", bus.mac_start, bus.mac_row_size);
      end
      seen_done = 1'b0;
      for (int c = 0; c < 100 && !seen_done; c++) begin
         if (bus.out_valid) begin
            e = sbq.pop_front();
            total++;
            if ({bus.out_data, bus.out_row, bus.out_col, bus.out_last} !== {e.data, e.tag.row, e.tag.col, e.tag.last}) begin
               bad++; $display("FAIL t4_out2 got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", bus.out_data, bus.out_row,
                               bus.out_col, bus.out_last, e.data, e.tag.row, e.tag.col, e.tag.last);
            end
         end
         seen_done = bus.job_done;
         @(negedge clk);
      end
      total++;
      if (!seen_done || sbq.size() != 0) begin bad++; $display("FAIL t4_end got=done%b left%0d exp=done1 left0", seen_done, sbq.size()); sbq.delete(); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   seen_done = 1'b0;
      int   leak = 0;
      bus.out_ready = 1'b1;
      start_job(2, 2, 5);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({bus.job_ready, bus.busy, bus.mac_start, bus.out_valid, bus.job_done} !== 5'b10000) begin
         bad++; $display("FAIL t5_abort_ctrl got=%b exp=10000", {bus.job_ready, bus.busy, bus.mac_start, bus.out_valid, bus.job_done});
      end
      total++;
      if ({bus.out_data, bus.out_row, bus.out_col, bus.mac_row_size, bus.a_row_idx} !== '0) begin
         bad++; $display("FAIL t5_abort_data got=%h/%h/%h/%h/%h exp=0", bus.out_data, bus.out_row, bus.out_col,
                         bus.mac_row_size, bus.a_row_idx);
      end
      sbq.delete();
      repeat (3) begin
         @(negedge clk);
         if (bus.out_valid || bus.job_done) leak++;
      end
      rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid || bus.job_done) leak++;
      end
      total++;
      if (leak != 0) begin bad++; $display("FAIL t5_no_leak got=%0d cycles exp=0", leak); end
      start_job(1, 1, 3);
      for (int c = 0; c < 100 && !seen_done; c++) begin
         if (bus.out_valid) begin
            total++;
            if (sbq.size() == 0) begin
               bad++; $display("FAIL t5_out got=extra %h exp=none", bus.out_data);
            end else begin
               e = sbq.pop_front();
               if ({bus.out_data, bus.out_row, bus.out_col, bus.out_last} !== {e.data, e.tag.row, e.tag.col, e.tag.last}) begin
                  bad++; $display("FAIL t5_out got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", bus.out_data, bus.out_row,
                                  bus.out_col, bus.out_last, e.data, e.tag.row, e.tag.col, e.tag.last);
               end
            end
         end
         seen_done = bus.job_done;
         @(negedge clk);
      end
      total++;
      if (!seen_done || sbq.size() != 0) begin bad++; $display("FAIL t5_end got=done%b left%0d exp=done1 left0", seen_done, sbq.size()); sbq.delete(); end
   endtask

`ifdef GEMM_SCHED_PERF_EN
   task automatic test_perf();
      exp_t e;
      bus.out_ready = 1'b0;
      start_job(1, 1, 4);
      for (int c = 0; c < 100 && !bus.out_valid; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      bus.out_ready = 1'b1;
      e = sbq.pop_front();
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, e.data, e.tag.last}) begin
         bad++; $display("FAIL t6_out got=v%b %0d/%b exp=v1 %0d/%b", bus.out_valid, bus.out_data, bus.out_last, e.data, e.tag.last);
      end
      @(negedge clk);
      total++;
      if (bus.job_done !== 1'b1) begin bad++; $display("FAIL t6_done got=%b exp=1", bus.job_done); end
      @(negedge clk);
      total++;
      if (bus.perf_stalls !== 32'd3) begin bad++; $display("FAIL t6_stalls got=%0d exp=3", bus.perf_stalls); end
      total++;
      if (bus.perf_cycles !== 32'd11) begin bad++; $display("FAIL t6_cycles got=%0d exp=11", bus.perf_cycles); end
      repeat (3) @(negedge clk);
      total++;
      if ({bus.perf_cycles, bus.perf_stalls} !== {32'd11, 32'd3}) begin
         bad++; $display("FAIL t6_hold got=%0d/%0d exp=11/3", bus.perf_cycles, bus.perf_stalls);
      end
   endtask
`endif

   initial begin
      bus.job_valid = 1'b0;
      bus.job_m     = '0;
      bus.job_p     = '0;
      bus.job_k     = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_zero_dim();
      test_back_to_back();
      test_reset_mid();
`ifdef GEMM_SCHED_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
